// File: rtl/multi_channel_edge_detector.sv
// Multi-channel edge detector.
// Each channel is synchronized, compared against its previous level, and
// turned into mode-qualified edge pulses. The block also keeps sticky flags
// and a saturating event counter.
// Optional feature: define EDGE_GLITCH_FILTER_EN to place a FILTER_LEN-cycle
// stability filter between the synchronized level and the edge logic.
// Without the macro, no filter logic is built and FILTER_LEN is ignored.
module multi_channel_edge_detector #(
    parameter int unsigned CH          = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned FILTER_LEN  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       signal_in,
    input  logic [2*CH-1:0]     mode,
    input  logic [CH-1:0]       sticky_clr,
    input  logic                cnt_clr,
    output logic [CH-1:0]       edge_out,
    output logic [CH-1:0]       edge_dir,
    output logic [CH-1:0]       sticky,
    output logic [CNT_W-1:0]    evt_count,
    output logic                cnt_sat
);

`ifdef EDGE_GLITCH_FILTER_EN
    localparam bit          FILT_EN = 1'b1;
`else
    localparam bit          FILT_EN = 1'b0;
`endif
    // Warm-up covers the synchronizer, the prev-level register and, when present, the filter.
    localparam int unsigned WARM_N = SYNC_STAGES + 1 + (FILT_EN ? FILTER_LEN : 0);
    localparam int unsigned WARM_W = $clog2(WARM_N + 1);
    localparam int unsigned PC_W   = $clog2(CH + 1);
    localparam int unsigned SUM_W  = CNT_W + 1;

    logic [CH-1:0][SYNC_STAGES-1:0] sync_q;
    logic [CH-1:0]                  level;
    logic [CH-1:0]                  det_lvl;
    logic [CH-1:0]                  prev_q;
    logic [WARM_W-1:0]              warm_q;
    logic                           armed;
    logic [CH-1:0]                  hit_r;
    logic [CH-1:0]                  hit_f;
    logic [PC_W-1:0]                pop;
    logic [CNT_W-1:0]               cnt_base;
    logic [SUM_W-1:0]               cnt_sum;
    logic [CNT_W-1:0]               cnt_next;

    // Per-channel synchronizer chain; the last stage is the channel level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            for (int i = 0; i < int'(CH); i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], signal_in[i]};
            end
        end
    end

    // Pick the synchronized level out of each chain.
    always_comb begin
        level = '0;
        for (int i = 0; i < int'(CH); i++) begin
            level[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

`ifdef EDGE_GLITCH_FILTER_EN
    localparam int unsigned FC_W = $clog2(FILTER_LEN + 1);

    logic [CH-1:0]            filt_q;
    logic [CH-1:0][FC_W-1:0]  fcnt_q;

    // Filtered level flips only after the raw level disagrees for FILTER_LEN cycles in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= '0;
            fcnt_q <= '0;
        end else begin
            for (int i = 0; i < int'(CH); i++) begin
                if (level[i] != filt_q[i]) begin
                    if (fcnt_q[i] == FC_W'(FILTER_LEN - 1)) begin
                        filt_q[i] <= level[i];
                        fcnt_q[i] <= '0;
                    end else begin
                        fcnt_q[i] <= fcnt_q[i] + FC_W'(1);
                    end
                end else begin
                    fcnt_q[i] <= '0;
                end
            end
        end
    end

    assign det_lvl = filt_q;
`else
    assign det_lvl = level;
`endif

    // Warm-up counter: detection stays masked until it reaches WARM_N.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm_q <= '0;
        end else if (!armed) begin
            warm_q <= warm_q + WARM_W'(1);
        end
    end

    assign armed = (warm_q == WARM_W'(WARM_N));

    // Previous-level register tracks the detected level every cycle, including warm-up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
        end else begin
            prev_q <= det_lvl;
        end
    end

    // Mode-qualified rise/fall detection; mode bit 2i enables rising, 2i+1 falling.
    always_comb begin
        hit_r = '0;
        hit_f = '0;
        for (int i = 0; i < int'(CH); i++) begin
            hit_r[i] = armed & det_lvl[i] & ~prev_q[i] & mode[2*i];
            hit_f[i] = armed & ~det_lvl[i] & prev_q[i] & mode[2*i+1];
        end
    end

    // Registered edge pulse and direction; direction holds between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_out <= '0;
            edge_dir <= '0;
        end else begin
            edge_out <= hit_r | hit_f;
            for (int i = 0; i < int'(CH); i++) begin
                if (hit_r[i] | hit_f[i]) begin
                    edge_dir[i] <= hit_r[i];
                end
            end
        end
    end

    // Sticky flags latch visible pulses; a pulse wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky <= '0;
        end else begin
            sticky <= (sticky & ~sticky_clr) | edge_out;
        end
    end

    // Popcount of the pulses visible this cycle, then clear-then-add with saturation.
    always_comb begin
        pop = '0;
        for (int i = 0; i < int'(CH); i++) begin
            pop = pop + PC_W'(edge_out[i]);
        end
        cnt_base = cnt_clr ? '0 : evt_count;
        cnt_sum  = {1'b0, cnt_base} + SUM_W'(pop);
        cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end

    // Event counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_count <= '0;
        end else begin
            evt_count <= cnt_next;
        end
    end

    assign cnt_sat = (evt_count == '1);

endmodule

// File: tb/tb_multi_channel_edge_detector.sv
// Directed self-checking bench for multi_channel_edge_detector (CH=4, SYNC_STAGES=2, CNT_W=8).
module tb_multi_channel_edge_detector;

    logic       clk;
    logic       rst;
    logic [3:0] signal_in;
    logic [7:0] mode;
    logic [3:0] sticky_clr;
    logic       cnt_clr;
    logic [3:0] edge_out;
    logic [3:0] edge_dir;
    logic [3:0] sticky;
    logic [7:0] evt_count;
    logic       cnt_sat;

    int n_cmp;
    int n_err;

    multi_channel_edge_detector #(
        .CH(4), .SYNC_STAGES(2), .CNT_W(8), .FILTER_LEN(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .signal_in(signal_in),
        .mode(mode),
        .sticky_clr(sticky_clr),
        .cnt_clr(cnt_clr),
        .edge_out(edge_out),
        .edge_dir(edge_dir),
        .sticky(sticky),
        .evt_count(evt_count),
        .cnt_sat(cnt_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        signal_in = 4'h0;
        mode = 8'hFF;
        sticky_clr = 4'h0;
        cnt_clr = 1'b1;
        repeat (3) tick();
        n_cmp++; if (edge_out !== 4'h0) begin n_err++; $display("FAIL reset_edge_out: got %b want %b", edge_out, 4'h0); end
        n_cmp++; if (edge_dir !== 4'h0) begin n_err++; $display("FAIL reset_edge_dir: got %b want %b", edge_dir, 4'h0); end
        n_cmp++; if (sticky !== 4'h0) begin n_err++; $display("FAIL reset_sticky: got %b want %b", sticky, 4'h0); end
        n_cmp++; if (evt_count !== 8'd0) begin n_err++; $display("FAIL reset_evt_count: got %0d want %0d", evt_count, 0); end
        n_cmp++; if (cnt_sat !== 1'b0) begin n_err++; $display("FAIL reset_cnt_sat: got %b want %b", cnt_sat, 1'b0); end
        cnt_clr = 1'b0;
        rst = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_basic_both();
        signal_in = 4'b0001;
        tick(); tick();
        n_cmp++; if (edge_out !== 4'b0000) begin n_err++; $display("FAIL basic_early: got %b want %b", edge_out, 4'b0000); end
        tick();
        n_cmp++; if (edge_out !== 4'b0001) begin n_err++; $display("FAIL basic_rise_pulse: got %b want %b", edge_out, 4'b0001); end
        n_cmp++; if (edge_dir !== 4'b0001) begin n_err++; $display("FAIL basic_rise_dir: got %b want %b", edge_dir, 4'b0001); end
        tick();
        n_cmp++; if (edge_out !== 4'b0000) begin n_err++; $display("FAIL basic_rise_end: got %b want %b", edge_out, 4'b0000); end
        n_cmp++; if (edge_dir !== 4'b0001) begin n_err++; $display("FAIL basic_dir_hold: got %b want %b", edge_dir, 4'b0001); end
        signal_in = 4'b0000;
        repeat (3) tick();
        n_cmp++; if (edge_out !== 4'b0001) begin n_err++; $display("FAIL basic_fall_pulse: got %b want %b", edge_out, 4'b0001); end
        n_cmp++; if (edge_dir !== 4'b0000) begin n_err++; $display("FAIL basic_fall_dir: got %b want %b", edge_dir, 4'b0000); end
        tick();
        n_cmp++; if (evt_count !== 8'd2) begin n_err++; $display("FAIL basic_count: got %0d want %0d", evt_count, 2); end
        n_cmp++; if (sticky !== 4'b0001) begin n_err++; $display("FAIL basic_sticky: got %b want %b", sticky, 4'b0001); end
    endtask

    task automatic test_mode_mix();
        mode = 8'b01_10_11_00;
        signal_in = 4'hF;
        repeat (3) tick();
        n_cmp++; if (edge_out !== 4'b1010) begin n_err++; $display("FAIL mode_rise_pulse: got %b want %b", edge_out, 4'b1010); end
        n_cmp++; if (edge_dir !== 4'b1010) begin n_err++; $display("FAIL mode_rise_dir: got %b want %b", edge_dir, 4'b1010); end
        tick();
        n_cmp++; if (evt_count !== 8'd4) begin n_err++; $display("FAIL mode_rise_count: got %0d want %0d", evt_count, 4); end
        signal_in = 4'h0;
        repeat (3) tick();
        n_cmp++; if (edge_out !== 4'b0110) begin n_err++; $display("FAIL mode_fall_pulse: got %b want %b", edge_out, 4'b0110); end
        n_cmp++; if (edge_dir !== 4'b1000) begin n_err++; $display("FAIL mode_fall_dir: got %b want %b", edge_dir, 4'b1000); end
        tick();
        n_cmp++; if (evt_count !== 8'd6) begin n_err++; $display("FAIL mode_fall_count: got %0d want %0d", evt_count, 6); end
    endtask

    task automatic test_sticky();
        n_cmp++; if (sticky !== 4'b1111) begin n_err++; $display("FAIL sticky_all_set: got %b want %b", sticky, 4'b1111); end
        sticky_clr = 4'hF;
        tick();
        sticky_clr = 4'h0;
        n_cmp++; if (sticky !== 4'b0000) begin n_err++; $display("FAIL sticky_clear_all: got %b want %b", sticky, 4'b0000); end
        mode = 8'hFF;
        signal_in = 4'b0100;
        repeat (3) tick();
        n_cmp++; if (edge_out !== 4'b0100) begin n_err++; $display("FAIL sticky_pulse: got %b want %b", edge_out, 4'b0100); end
        sticky_clr = 4'b0100;
        tick();
        n_cmp++; if (sticky !== 4'b0100) begin n_err++; $display("FAIL sticky_set_wins: got %b want %b", sticky, 4'b0100); end
        tick();
        n_cmp++; if (sticky !== 4'b0000) begin n_err++; $display("FAIL sticky_clear_alone: got %b want %b", sticky, 4'b0000); end
        sticky_clr = 4'h0;
        n_cmp++; if (evt_count !== 8'd7) begin n_err++; $display("FAIL sticky_count: got %0d want %0d", evt_count, 7); end
    endtask

    task automatic test_back_to_back();
        signal_in = 4'b0110;
        tick();
        signal_in = 4'b0100;
        tick();
        signal_in = 4'b0110;
        tick();
        n_cmp++; if (edge_out !== 4'b0010) begin n_err++; $display("FAIL b2b_pulse1: got %b want %b", edge_out, 4'b0010); end
        n_cmp++; if (edge_dir !== 4'b1110) begin n_err++; $display("FAIL b2b_dir1: got %b want %b", edge_dir, 4'b1110); end
        tick();
        n_cmp++; if (edge_out !== 4'b0010) begin n_err++; $display("FAIL b2b_pulse2: got %b want %b", edge_out, 4'b0010); end
        n_cmp++; if (edge_dir !== 4'b1100) begin n_err++; $display("FAIL b2b_dir2: got %b want %b", edge_dir, 4'b1100); end
        tick();
        n_cmp++; if (edge_out !== 4'b0010) begin n_err++; $display("FAIL b2b_pulse3: got %b want %b", edge_out, 4'b0010); end
        n_cmp++; if (edge_dir !== 4'b1110) begin n_err++; $display("FAIL b2b_dir3: got %b want %b", edge_dir, 4'b1110); end
        tick();
        n_cmp++; if (edge_out !== 4'b0000) begin n_err++; $display("FAIL b2b_end: got %b want %b", edge_out, 4'b0000); end
        n_cmp++; if (evt_count !== 8'd10) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", evt_count, 10); end
    endtask

    task automatic test_saturation();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        n_cmp++; if (evt_count !== 8'd0) begin n_err++; $display("FAIL sat_clear: got %0d want %0d", evt_count, 0); end
        for (int i = 0; i < 254; i++) begin
            signal_in[0] = ~signal_in[0];
            tick();
        end
        repeat (4) tick();
        n_cmp++; if (evt_count !== 8'd254) begin n_err++; $display("FAIL sat_254: got %0d want %0d", evt_count, 254); end
        n_cmp++; if (cnt_sat !== 1'b0) begin n_err++; $display("FAIL sat_flag_254: got %b want %b", cnt_sat, 1'b0); end
        signal_in = signal_in ^ 4'b1001;
        repeat (3) tick();
        n_cmp++; if (edge_out !== 4'b1001) begin n_err++; $display("FAIL sat_two_pulse: got %b want %b", edge_out, 4'b1001); end
        tick();
        n_cmp++; if (evt_count !== 8'd255) begin n_err++; $display("FAIL sat_255: got %0d want %0d", evt_count, 255); end
        n_cmp++; if (cnt_sat !== 1'b1) begin n_err++; $display("FAIL sat_flag_255: got %b want %b", cnt_sat, 1'b1); end
        signal_in = signal_in ^ 4'b0001;
        repeat (4) tick();
        n_cmp++; if (evt_count !== 8'd255) begin n_err++; $display("FAIL sat_no_wrap: got %0d want %0d", evt_count, 255); end
        signal_in = signal_in ^ 4'b0001;
        repeat (3) tick();
        n_cmp++; if (edge_out !== 4'b0001) begin n_err++; $display("FAIL sat_clr_pulse: got %b want %b", edge_out, 4'b0001); end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        n_cmp++; if (evt_count !== 8'd1) begin n_err++; $display("FAIL sat_clr_then_count: got %0d want %0d", evt_count, 1); end
        n_cmp++; if (cnt_sat !== 1'b0) begin n_err++; $display("FAIL sat_flag_after_clr: got %b want %b", cnt_sat, 1'b0); end
    endtask

    task automatic test_high_through_reset();
        rst = 1'b1;
        signal_in = 4'hF;
        cnt_clr = 1'b1;
        sticky_clr = 4'hF;
        repeat (2) tick();
        rst = 1'b0;
        cnt_clr = 1'b0;
        sticky_clr = 4'h0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++; if (edge_out !== 4'h0) begin n_err++; $display("FAIL warmup_no_pulse cycle %0d: got %b want %b", i, edge_out, 4'h0); end
        end
        n_cmp++; if (sticky !== 4'h0) begin n_err++; $display("FAIL warmup_sticky: got %b want %b", sticky, 4'h0); end
        n_cmp++; if (evt_count !== 8'd0) begin n_err++; $display("FAIL warmup_count: got %0d want %0d", evt_count, 0); end
    endtask

    task automatic test_midpulse_reset();
        signal_in = 4'b1101;
        repeat (3) tick();
        n_cmp++; if (edge_out !== 4'b0010) begin n_err++; $display("FAIL midrst_pulse: got %b want %b", edge_out, 4'b0010); end
        rst = 1'b1;
        #1;
        n_cmp++; if (edge_out !== 4'b0000) begin n_err++; $display("FAIL midrst_async_drop: got %b want %b", edge_out, 4'b0000); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++; if (edge_out !== 4'h0) begin n_err++; $display("FAIL midrst_warmup cycle %0d: got %b want %b", i, edge_out, 4'h0); end
        end
        n_cmp++; if (evt_count !== 8'd0) begin n_err++; $display("FAIL midrst_count: got %0d want %0d", evt_count, 0); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic_both();
        test_mode_mix();
        test_sticky();
        test_back_to_back();
        test_saturation();
        test_high_through_reset();
        test_midpulse_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
